fetch_queue: RTL and testbench

//  Instruction-fetch front end between PC generation and the IF_ID pipeline register.

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 96 +++++++++
 tb/tb_fetch_queue.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_queue_pkg;

    localparam int unsigned DataSize = 32;
    localparam logic [DataSize-1:0] DataBusReset = '0;
    localparam logic [DataSize-1:0] NopInst = 32'h00000013;

    typedef enum logic [1:0] {
        FqIdle = 2'd0,
        FqWait = 2'd1,
        FqDrop = 2'd2
    } fq_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, inst} pairs; clear empties it and beats push/pop.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2 * DataSize
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FullCount);
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues one imem request at a time and
// queues returned {pc, inst} pairs for IF_ID; redirects flush and refetch.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       DATA_W   = DataSize,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NopInst)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirectAddr,
    input  logic              locker,
    output logic              imemReq,
    output logic [DATA_W-1:0] imemAddr,
    input  logic              imemGnt,
    input  logic              imemValid,
    input  logic [DATA_W-1:0] imemData,
    output logic              instValid,
    output logic [DATA_W-1:0] instOut,
    output logic [DATA_W-1:0] pcOut
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fq_state_e           state;
    logic [DATA_W-1:0]   fetch_pc;
    logic [DATA_W-1:0]   pc_of_req;
    logic [CntW-1:0]     fifo_count;
    logic [2*DATA_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    // Issue only with room guaranteed, so a response never meets a full FIFO.
    assign imemReq  = !reset && (state == FqIdle) && !fifo_full && !redirect;
    assign imemAddr = fetch_pc;
    assign push     = (state == FqWait) && imemValid && !redirect;
    assign pop      = !fifo_empty && !locker && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FqIdle;
            fetch_pc  <= RESET_PC;
            pc_of_req <= DATA_W'(DataBusReset);
        end else if (redirect) begin
            fetch_pc <= redirectAddr;
            // An outstanding request still owes a response that must be discarded.
            unique case (state)
                FqWait:  state <= imemValid ? FqIdle : FqDrop;
                FqDrop:  state <= imemValid ? FqIdle : FqDrop;
                default: state <= state;
            endcase
        end else begin
            unique case (state)
                FqIdle: begin
                    if (imemReq && imemGnt) begin
                        fetch_pc  <= fetch_pc + DATA_W'(4);
                        pc_of_req <= fetch_pc;
                        state     <= FqWait;
                    end
                end
                FqWait, FqDrop: begin
                    if (imemValid) begin
                        state <= FqIdle;
                    end
                end
                default: state <= FqIdle;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   ({pc_of_req, imemData}),
        .count (fifo_count),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instValid = !fifo_empty;
    assign instOut   = fifo_empty ? NOP_INST : fifo_head[DATA_W-1:0];
    assign pcOut     = fifo_empty ? DATA_W'(DataBusReset) : fifo_head[2*DATA_W-1:DATA_W];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scripted memory responder, an expected-pop
// scoreboard filled by the stimulus, and a monitor that checks every consumed head.
module tb_fetch_queue;

    localparam logic [31:0] Nop = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirectAddr;
    logic        locker;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemValid;
    logic [31:0] imemData;
    logic        instValid;
    logic [31:0] instOut;
    logic [31:0] pcOut;

    fetch_queue #(
        .DEPTH    (4),
        .DATA_W   (32),
        .RESET_PC (32'h00000000),
        .NOP_INST (32'h00000013)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect     (redirect),
        .redirectAddr (redirectAddr),
        .locker       (locker),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemGnt      (imemGnt),
        .imemValid    (imemValid),
        .imemData     (imemData),
        .instValid    (instValid),
        .instOut      (instOut),
        .pcOut        (pcOut)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Memory responder state
    int          gnt_budget = 0;
    int          mem_lat    = 1;
    bit          mem_busy   = 0;
    int          mem_cnt    = 0;
    logic [31:0] mem_addr   = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00500093;
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[23:0], 8'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic wait_busy(input string name);
        for (int i = 0; i < 20 && !mem_busy; i++) begin
            @(negedge clk);
            #2;
        end
        check(name, 32'(mem_busy), 32'd1);
    endtask

    // Memory: acts 1 time unit after the falling edge, after stimulus has settled.
    initial begin
        imemGnt   = 1'b0;
        imemValid = 1'b0;
        imemData  = '0;
        forever begin
            @(negedge clk);
            #1;
            imemGnt   = 1'b0;
            imemValid = 1'b0;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imemValid = 1'b1;
                    imemData  = mem_word(mem_addr);
                    mem_busy  = 0;
                end
            end
            if (!mem_busy && !imemValid && imemReq && gnt_budget > 0) begin
                imemGnt = 1'b1;
                gnt_budget--;
                mem_busy = 1;
                mem_cnt  = mem_lat;
                mem_addr = imemAddr;
            end
        end
    end

    // Monitor: a head consumed at the coming edge must match the scoreboard front.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && instValid && !locker && !redirect) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_unexpected: got pc=%h inst=%h, expected no entry",
                             pcOut, instOut);
                end else begin
                    e = exp_q.pop_front();
                    if (pcOut !== e.pc || instOut !== e.inst) begin
                        n_fail++;
                        $display("FAIL pop_order: got pc=%h inst=%h, expected pc=%h inst=%h",
                                 pcOut, instOut, e.pc, e.inst);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        redirect     = 1'b0;
        redirectAddr = '0;
        locker       = 1'b0;

        // T1: reset values, then a single zero-wait fetch from 0x0
        repeat (2) @(negedge clk);
        #2;
        check("t1_rst_req", 32'(imemReq), 32'd0);
        check("t1_rst_valid", 32'(instValid), 32'd0);
        check("t1_rst_inst", instOut, Nop);
        check("t1_rst_pc", pcOut, 32'h0);
        @(negedge clk);
        reset      = 1'b0;
        gnt_budget = 1;
        push_exp(32'h0, 32'h00500093);
        #2;
        check("t1_req", 32'(imemReq), 32'd1);
        check("t1_addr", imemAddr, 32'h0);
        for (int i = 0; i < 20 && !instValid; i++) begin
            @(negedge clk);
            #2;
        end
        check("t1_valid", 32'(instValid), 32'd1);
        check("t1_pc", pcOut, 32'h0);
        check("t1_inst", instOut, 32'h00500093);
        @(negedge clk);
        #2;
        check("t1_empty_valid", 32'(instValid), 32'd0);
        check("t1_empty_inst", instOut, Nop);

        // T2: locker held, FIFO fills to 4 and issue stops; then drain in order
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset      = 1'b0;
        locker     = 1'b1;
        gnt_budget = 4;
        push_exp(32'h0, 32'h00500093);
        push_exp(32'h4, 32'h00000413);
        push_exp(32'h8, 32'h00000813);
        push_exp(32'hC, 32'h00000C13);
        repeat (12) @(negedge clk);
        #2;
        check("t2_full_req", 32'(imemReq), 32'd0);
        check("t2_count", 32'(dut.fifo_count), 32'd4);
        check("t2_head_pc", pcOut, 32'h0);
        @(negedge clk);
        locker = 1'b0;
        #2;
        check("t2_pc0", pcOut, 32'h0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            #2;
            check("t2_pc", pcOut, 32'(4 * i));
        end
        @(negedge clk);
        #2;
        check("t2_empty_valid", 32'(instValid), 32'd0);
        check("t2_empty_inst", instOut, Nop);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // T3: redirect during WAIT, response (0xDEADBEEF) arrives a cycle later
        @(negedge clk);
        mem_lat    = 2;
        gnt_budget = 1;
        #2;
        wait_busy("t3_gnt");
        @(negedge clk);
        redirect     = 1'b1;
        redirectAddr = 32'h40;
        exp_q.delete();
        #2;
        check("t3_req_redirect", 32'(imemReq), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #2;
        check("t3_drop_req", 32'(imemReq), 32'd0);
        check("t3_drop_valid", 32'(instValid), 32'd0);
        @(negedge clk);
        #2;
        check("t3_refetch_req", 32'(imemReq), 32'd1);
        check("t3_refetch_addr", imemAddr, 32'h40);
        check("t3_valid", 32'(instValid), 32'd0);

        // T4: redirect on the same edge as the response
        @(negedge clk);
        mem_lat    = 1;
        gnt_budget = 1;
        #2;
        wait_busy("t4_gnt");
        @(negedge clk);
        redirect     = 1'b1;
        redirectAddr = 32'h80;
        #2;
        check("t4_req_redirect", 32'(imemReq), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #2;
        check("t4_refetch_req", 32'(imemReq), 32'd1);
        check("t4_refetch_addr", imemAddr, 32'h80);
        check("t4_valid", 32'(instValid), 32'd0);

        // T5: push and pop together at count 3, then run through pointer wrap
        @(negedge clk);
        locker     = 1'b1;
        gnt_budget = 3;
        push_exp(32'h80, 32'h00008013);
        push_exp(32'h84, 32'h00008413);
        push_exp(32'h88, 32'h00008813);
        push_exp(32'h8C, 32'h00008C13);
        repeat (10) @(negedge clk);
        #2;
        check("t5_count3", 32'(dut.fifo_count), 32'd3);
        @(negedge clk);
        gnt_budget = 1;
        #2;
        wait_busy("t5_gnt");
        @(negedge clk);
        locker = 1'b0;
        #2;
        check("t5_resp_valid", 32'(imemValid), 32'd1);
        check("t5_pre_count", 32'(dut.fifo_count), 32'd3);
        @(negedge clk);
        locker = 1'b1;
        #2;
        check("t5_post_count", 32'(dut.fifo_count), 32'd3);
        check("t5_head_pc", pcOut, 32'h84);
        @(negedge clk);
        locker     = 1'b0;
        gnt_budget = 6;
        push_exp(32'h90, 32'h00009013);
        push_exp(32'h94, 32'h00009413);
        push_exp(32'h98, 32'h00009813);
        push_exp(32'h9C, 32'h00009C13);
        push_exp(32'hA0, 32'h0000A013);
        push_exp(32'hA4, 32'h0000A413);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // T6: reset while a request is in flight with three entries queued
        @(negedge clk);
        locker     = 1'b1;
        mem_lat    = 1;
        gnt_budget = 3;
        push_exp(32'hA8, 32'h0000A813);
        push_exp(32'hAC, 32'h0000AC13);
        push_exp(32'hB0, 32'h0000B013);
        repeat (10) @(negedge clk);
        #2;
        check("t6_count3", 32'(dut.fifo_count), 32'd3);
        @(negedge clk);
        mem_lat    = 4;
        gnt_budget = 1;
        #2;
        wait_busy("t6_gnt");
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #2;
        check("t6_rst_req", 32'(imemReq), 32'd0);
        check("t6_rst_valid", 32'(instValid), 32'd0);
        check("t6_rst_inst", instOut, Nop);
        check("t6_rst_pc", pcOut, 32'h0);
        @(negedge clk);
        reset  = 1'b0;
        locker = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #2;
            check("t6_stray_ignored", 32'(instValid), 32'd0);
        end
        check("t6_addr", imemAddr, 32'h0);
        check("t6_req", 32'(imemReq), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
